// File: rtl/ps2_scancode_sequencer_pkg.sv
// Shared definitions for the PS/2 scancode sequencer: FSM states, protocol
// byte constants, event layout and error-bit positions.
package ps2_scancode_sequencer_pkg;

  localparam int EVT_W = 10;

  // Parser state: which prefix bytes have been seen for the current code.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } state_t;

  // Protocol bytes from the keyboard.
  localparam logic [7:0] BYTE_E0 = 8'hE0;  // extended-key prefix
  localparam logic [7:0] BYTE_F0 = 8'hF0;  // break (release) prefix
  localparam logic [7:0] BYTE_AA = 8'hAA;  // BAT passed
  localparam logic [7:0] BYTE_FA = 8'hFA;  // ACK
  localparam logic [7:0] BYTE_FE = 8'hFE;  // resend request
  localparam logic [7:0] BYTE_FC = 8'hFC;  // BAT failed
  localparam logic [7:0] BYTE_00 = 8'h00;  // key detection error / overrun
  localparam logic [7:0] BYTE_FF = 8'hFF;  // key detection error / overrun

  // Sticky error bit positions in err[2:0].
  localparam int ERR_OVF = 2;
  localparam int ERR_TMO = 1;
  localparam int ERR_KBD = 0;

  // One decoded key event as stored in the FIFO.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  function automatic evt_t mk_evt(input logic ext, input logic brk,
                                  input logic [7:0] code);
    evt_t e;
    e.ext  = ext;
    e.brk  = brk;
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Small synchronous event FIFO. A push while full is dropped unless a pop
// happens in the same cycle; a pop while empty is ignored. The head output
// reads as zero when empty so the consumer never sees stale data.
module ps2_evt_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 10,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot this cycle, so a push into a full FIFO still lands.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, head is gated.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ps2_scancode_sequencer.sv
// Turns the raw PS/2 byte stream into {ext, brk, code} key events, tracking
// E0/F0 prefixes, abandoning half-received codes after a timeout, and
// flagging keyboard status bytes. Events are queued in ps2_evt_fifo.
module ps2_scancode_sequencer
  import ps2_scancode_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [9:0] evt_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] evt_count,
  output logic       kbd_ok,
  output logic [2:0] err,
  input  logic       err_clr
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int              CW       = $clog2(FIFO_DEPTH) + 1;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]    err_q, err_d;
  logic          kbd_ok_q, kbd_ok_d;

  logic          push;
  evt_t          push_evt;
  logic          set_ok, set_kbd, set_tmo, set_ovf;
  logic          pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [9:0]    fifo_head;

  assign pop       = evt_valid & evt_ready;
  assign evt_valid = ~fifo_empty;
  assign evt_data  = fifo_head;
  assign evt_count = 5'(fifo_count);
  assign kbd_ok    = kbd_ok_q;
  assign err       = err_q;

  // Byte parser and prefix timeout: next state, event push and error events.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    push     = 1'b0;
    push_evt = '0;
    set_ok   = 1'b0;
    set_kbd  = 1'b0;
    set_tmo  = 1'b0;
    if (rx_valid) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          case (rx_data)
            BYTE_E0:                   state_d = ST_GOT_E0;
            BYTE_F0:                   state_d = ST_GOT_F0;
            BYTE_AA:                   set_ok  = 1'b1;
            BYTE_FC, BYTE_00, BYTE_FF: set_kbd = 1'b1;
            BYTE_FA, BYTE_FE:          ;
            default: begin
              push     = 1'b1;
              push_evt = mk_evt(1'b0, 1'b0, rx_data);
            end
          endcase
        end
        ST_GOT_E0: begin
          if (rx_data == BYTE_F0) begin
            state_d = ST_GOT_E0F0;
          end else if (rx_data != BYTE_E0) begin
            push     = 1'b1;
            push_evt = mk_evt(1'b1, 1'b0, rx_data);
            state_d  = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          push     = 1'b1;
          push_evt = mk_evt(1'b0, 1'b1, rx_data);
          state_d  = ST_IDLE;
        end
        ST_GOT_E0F0: begin
          push     = 1'b1;
          push_evt = mk_evt(1'b1, 1'b1, rx_data);
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      // Prefix arrived but the final byte never did: drop the partial code.
      state_d = ST_IDLE;
      tmo_d   = '0;
      set_tmo = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Sticky status: a clear and a new event in the same cycle keeps the bit.
  always_comb begin
    set_ovf  = push & fifo_full & ~pop;
    err_d    = (err_clr ? 3'b000 : err_q);
    err_d[ERR_OVF] = err_d[ERR_OVF] | set_ovf;
    err_d[ERR_TMO] = err_d[ERR_TMO] | set_tmo;
    err_d[ERR_KBD] = err_d[ERR_KBD] | set_kbd;
    kbd_ok_d = (kbd_ok_q & ~err_clr) | set_ok;
  end

  // State, timeout counter and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      err_q    <= '0;
      kbd_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      kbd_ok_q <= kbd_ok_d;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Bench for ps2_scancode_sequencer: directed scenarios followed by random
// byte traffic, all checked every cycle against a queue-based reference.
`timescale 1ns/1ps
module tb_ps2_scancode_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [9:0] evt_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [4:0] evt_count;
  logic       kbd_ok;
  logic [2:0] err;
  logic       err_clr;

  int total = 0;
  int bad   = 0;

  // Reference model: pending prefix flags, idle gap counter, event queue.
  logic [9:0] mq[$];
  bit         m_e0, m_f0, m_ok;
  int         m_gap;
  logic [2:0] m_err;

  ps2_scancode_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .evt_data  (evt_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_count (evt_count),
    .kbd_ok    (kbd_ok),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_e0 = 0; m_f0 = 0; m_ok = 0; m_gap = 0; m_err = 3'b000;
  endtask

  // One clock edge of the reference behaviour, using the inputs now applied.
  task automatic model_step();
    bit         pop, ev, full, set_ok;
    logic [9:0] evv;
    logic [2:0] es;
    pop = evt_ready && (mq.size() != 0);
    full = (mq.size() == DEPTH);
    ev = 0; evv = '0; es = 3'b000; set_ok = 0;
    if (rx_valid) begin
      m_gap = 0;
      if (!m_e0 && !m_f0) begin
        case (rx_data)
          8'hE0: m_e0 = 1;
          8'hF0: m_f0 = 1;
          8'hAA: set_ok = 1;
          8'hFC, 8'h00, 8'hFF: es[0] = 1;
          8'hFA, 8'hFE: ;
          default: begin ev = 1; evv = {2'b00, rx_data}; end
        endcase
      end else if (m_f0) begin
        ev = 1; evv = {m_e0, 1'b1, rx_data}; m_e0 = 0; m_f0 = 0;
      end else if (rx_data == 8'hF0) begin
        m_f0 = 1;
      end else if (rx_data != 8'hE0) begin
        ev = 1; evv = {2'b10, rx_data}; m_e0 = 0;
      end
    end else if (m_e0 || m_f0) begin
      m_gap++;
      if (m_gap >= TMO) begin
        m_e0 = 0; m_f0 = 0; m_gap = 0; es[1] = 1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (ev) begin
      if (full && !pop) es[2] = 1;
      else mq.push_back(evv);
    end
    if (err_clr) begin m_err = 3'b000; m_ok = 0; end
    m_err = m_err | es;
    if (set_ok) m_ok = 1;
  endtask

  task automatic chk_all();
    chk("evt_valid", evt_valid, mq.size() != 0);
    chk("evt_count", evt_count, mq.size());
    chk("evt_data", evt_data, (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("err", err, m_err);
    chk("kbd_ok", kbd_ok, m_ok);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
    chk_all();
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, evt_valid, 0);
    chk({tag, "_count"}, evt_count, 0);
    chk({tag, "_data"}, evt_data, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ok"}, kbd_ok, 0);
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; evt_ready = 1'b0; err_clr = 1'b0;
    model_clear();
    #1;
    chk_all_zero("reset");
    tick(); tick();
    reset = 1'b0;
    tick();

    // Make then break, consumer always ready.
    evt_ready = 1'b1;
    send(8'h1C);
    chk("make_1c", evt_data, 10'h01C);
    send(8'hF0);
    send(8'h1C);
    chk("break_1c_valid", evt_valid, 1);
    chk("break_1c", evt_data, 10'h11C);

    // Extended make and extended break.
    send(8'hE0); send(8'h75);
    chk("ext_make", evt_data, 10'h275);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_break", evt_data, 10'h375);
    tick();

    // Overflow: six makes into a four-deep FIFO with no consumer.
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'(8'h15 + i));
    chk("ovf_count", evt_count, 4);
    chk("ovf_err", err, 3'b100);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop", evt_data, 10'(10'h015 + i));
      tick();
    end
    chk("ovf_drained", evt_count, 0);
    tick();
    pulse_clr();

    // Simultaneous push and pop when full, then at occupancy one.
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h21 + i));
    evt_ready = 1'b1;
    send(8'h25);
    chk("full_pp_count", evt_count, 4);
    chk("full_pp_err", err, 0);
    chk("full_pp_head", evt_data, 10'h022);
    repeat (5) tick();
    evt_ready = 1'b0;
    send(8'h31);
    evt_ready = 1'b1;
    send(8'h32);
    chk("one_pp_count", evt_count, 1);
    chk("one_pp_head", evt_data, 10'h032);
    repeat (3) tick();

    // Timeout boundary: one cycle short survives, full window aborts.
    send(8'hE0);
    repeat (TMO - 1) tick();
    chk("tmo_short_err", err, 0);
    send(8'h75);
    chk("tmo_short_evt", evt_data, 10'h275);
    send(8'hE0);
    repeat (TMO) tick();
    chk("tmo_err", err, 3'b010);
    send(8'h1C);
    chk("tmo_next", evt_data, 10'h01C);
    tick();
    pulse_clr();

    // Status bytes, then clear coinciding with a new keyboard error.
    send(8'hAA); send(8'hFC); send(8'hFA);
    chk("stat_ok", kbd_ok, 1);
    chk("stat_err", err, 3'b001);
    chk("stat_none", evt_count, 0);
    err_clr = 1'b1;
    send(8'hFF);
    err_clr = 1'b0;
    chk("clr_set_wins", err, 3'b001);
    chk("clr_ok", kbd_ok, 0);
    pulse_clr();
    chk("clr_all", err, 0);

    // Asynchronous reset mid-sequence with events queued.
    evt_ready = 1'b0;
    send(8'h41); send(8'h42); send(8'hF0);
    reset = 1'b1;
    #2;
    model_clear();
    chk_all_zero("async_rst");
    tick();
    reset = 1'b0;
    evt_ready = 1'b1;
    send(8'h1C);
    chk("rst_make", evt_data, 10'h01C);
    tick();

    // Random traffic; some windows are sparse so prefixes time out.
    for (int c = 0; c < 1500; c++) begin
      int r;
      bit sparse;
      sparse = ((c / 150) % 2) == 1;
      rx_valid  = sparse ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 15);
      case (r)
        0, 1, 2: rx_data = 8'hE0;
        3, 4:    rx_data = 8'hF0;
        5:       rx_data = 8'hAA;
        6:       rx_data = 8'hFC;
        7:       rx_data = 8'hFA;
        8:       rx_data = 8'hFE;
        9:       rx_data = 8'h00;
        10:      rx_data = 8'hFF;
        default: rx_data = 8'($urandom_range(0, 255));
      endcase
      evt_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 40) == 0);
      tick();
    end
    rx_valid = 1'b0; err_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
